add_sub: RTL and testbench

Channel-separation stage of the FM radio stereo path. Pops one L+R sample and one L−R sample from the two upstream FIFOs, forms left = (L+R)+(L−R) and right = (L+R)−(L−R), and pushes the results into the left and right channel FIFOs. Those FIFOs feed the de-emphasis IIR filters (`iir_top`) for each channel.

---
 rtl/fm_radio_pkg.sv | 11 +
 rtl/add_sub.sv | 80 ++++++++
 tb/tb_add_sub.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fm_radio_pkg.sv
// Shared definitions for the FM radio stereo path.
package fm_radio_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 32;

   typedef enum logic {
      S_READ  = 1'b0,
      S_WRITE = 1'b1
   } add_sub_state_t;

endpackage

// File: rtl/add_sub.sv
// Stereo channel separation: left = (L+R)+(L-R), right = (L+R)-(L-R).
// Pops one pair from the L+R/L-R FIFOs, then pushes one pair to the left/right FIFOs.
module add_sub
   import fm_radio_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] lpr_dout,
   input  logic                  lpr_empty,
   output logic                  lpr_rd_en,
   input  logic [DATA_WIDTH-1:0] lmr_dout,
   input  logic                  lmr_empty,
   output logic                  lmr_rd_en,
   output logic [DATA_WIDTH-1:0] left_din,
   input  logic                  left_full,
   output logic                  left_wr_en,
   output logic [DATA_WIDTH-1:0] right_din,
   input  logic                  right_full,
   output logic                  right_wr_en,
   output logic [31:0]           sample_count
);

   add_sub_state_t        state_q, state_d;
   logic [DATA_WIDTH-1:0] left_q, left_d;
   logic [DATA_WIDTH-1:0] right_q, right_d;
   logic [31:0]           count_q, count_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_READ;
         left_q  <= '0;
         right_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         left_q  <= left_d;
         right_q <= right_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      left_d      = left_q;
      right_d     = right_q;
      count_d     = count_q;
      lpr_rd_en   = 1'b0;
      lmr_rd_en   = 1'b0;
      left_wr_en  = 1'b0;
      right_wr_en = 1'b0;
      unique case (state_q)
         S_READ: begin
            // Enables are combinational, so gate with reset to keep them low during reset.
            if (reset && !lpr_empty && !lmr_empty) begin
               lpr_rd_en = 1'b1;
               lmr_rd_en = 1'b1;
               left_d    = lpr_dout + lmr_dout;
               right_d   = lpr_dout - lmr_dout;
               state_d   = S_WRITE;
            end
         end
         S_WRITE: begin
            if (reset && !left_full && !right_full) begin
               left_wr_en  = 1'b1;
               right_wr_en = 1'b1;
               count_d     = count_q + 32'd1;
               state_d     = S_READ;
            end
         end
         default: state_d = S_READ;
      endcase
   end

   assign left_din     = left_q;
   assign right_din    = right_q;
   assign sample_count = count_q;

endmodule

// File: tb/tb_add_sub.sv
// Self-checking bench for add_sub: directed scenarios plus randomized streams
// checked against a queue-based model of the channel-separation rule.
module tb_add_sub;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] lpr_dout, lmr_dout, left_din, right_din, sample_count;
   logic        lpr_empty, lmr_empty, lpr_rd_en, lmr_rd_en;
   logic        left_full, right_full, left_wr_en, right_wr_en;

   int n_cmp  = 0;
   int n_fail = 0;
   int exp_count = 0;

   logic [31:0] src_lpr[$];
   logic [31:0] src_lmr[$];
   logic [31:0] exp_l[$];
   logic [31:0] exp_r[$];

   add_sub #(.DATA_WIDTH(32)) dut (
      .clock        (clock),
      .reset        (reset),
      .lpr_dout     (lpr_dout),
      .lpr_empty    (lpr_empty),
      .lpr_rd_en    (lpr_rd_en),
      .lmr_dout     (lmr_dout),
      .lmr_empty    (lmr_empty),
      .lmr_rd_en    (lmr_rd_en),
      .left_din     (left_din),
      .left_full    (left_full),
      .left_wr_en   (left_wr_en),
      .right_din    (right_din),
      .right_full   (right_full),
      .right_wr_en  (right_wr_en),
      .sample_count (sample_count)
   );

   always #5 clock = ~clock;

   // Reference arithmetic: 32-bit wrap-around sum and difference.
   function automatic logic [31:0] ref_left(input logic [31:0] a, input logic [31:0] b);
      return a + b;
   endfunction

   function automatic logic [31:0] ref_right(input logic [31:0] a, input logic [31:0] b);
      return a - b;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      lpr_dout   = '0;
      lmr_dout   = '0;
      lpr_empty  = 1'b1;
      lmr_empty  = 1'b1;
      left_full  = 1'b0;
      right_full = 1'b0;
   endtask

   task automatic fresh_reset();
      idle_inputs();
      reset = 1'b0;
      step();
      reset = 1'b1;
      exp_count = 0;
      step();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset     = 1'b0;
      lpr_dout  = 32'h5;
      lmr_dout  = 32'h3;
      lpr_empty = 1'b0;
      lmr_empty = 1'b0;
      step();
      step();
      n_cmp++;
      if ({lpr_rd_en, lmr_rd_en, left_wr_en, right_wr_en} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_enables: got %b expected 0000",
                  {lpr_rd_en, lmr_rd_en, left_wr_en, right_wr_en});
      end
      n_cmp++;
      if (left_din !== 32'h0 || right_din !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_din: got left=%h right=%h expected 0", left_din, right_din);
      end
      n_cmp++;
      if (sample_count !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_count: got %0d expected 0", sample_count);
      end
      idle_inputs();
      reset = 1'b1;
      exp_count = 0;
      step();
   endtask

   task automatic test_basic();
      lpr_dout  = 32'h0000_0400;
      lmr_dout  = 32'h0000_0100;
      lpr_empty = 1'b0;
      lmr_empty = 1'b0;
      #1;
      n_cmp++;
      if ({lpr_rd_en, lmr_rd_en, left_wr_en, right_wr_en} !== 4'b1100) begin
         n_fail++;
         $display("FAIL basic_pop: got %b expected 1100",
                  {lpr_rd_en, lmr_rd_en, left_wr_en, right_wr_en});
      end
      step();
      lpr_empty = 1'b1;
      lmr_empty = 1'b1;
      #1;
      n_cmp++;
      if ({lpr_rd_en, lmr_rd_en, left_wr_en, right_wr_en} !== 4'b0011) begin
         n_fail++;
         $display("FAIL basic_write_en: got %b expected 0011",
                  {lpr_rd_en, lmr_rd_en, left_wr_en, right_wr_en});
      end
      n_cmp++;
      if (left_din !== 32'h0000_0500 || right_din !== 32'h0000_0300) begin
         n_fail++;
         $display("FAIL basic_data: got left=%h right=%h expected 00000500 00000300",
                  left_din, right_din);
      end
      exp_count++;
      step();
      n_cmp++;
      if (sample_count !== 32'd1 || left_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_count: got count=%0d wr=%b expected 1 0",
                  sample_count, left_wr_en);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] va[3];
      logic [31:0] vb[3];
      logic [31:0] el[3];
      logic [31:0] er[3];
      va[0] = 32'h7FFF_FFFF; vb[0] = 32'h0000_0001; el[0] = 32'h8000_0000; er[0] = 32'h7FFF_FFFE;
      va[1] = 32'hFFFF_FF00; vb[1] = 32'h0000_0200; el[1] = 32'h0000_0100; er[1] = 32'hFFFF_FD00;
      va[2] = 32'h8000_0000; vb[2] = 32'h0000_0001; el[2] = 32'h8000_0001; er[2] = 32'h7FFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         lpr_dout  = va[i];
         lmr_dout  = vb[i];
         lpr_empty = 1'b0;
         lmr_empty = 1'b0;
         step();
         lpr_empty = 1'b1;
         lmr_empty = 1'b1;
         #1;
         n_cmp++;
         if (left_wr_en !== 1'b1 || left_din !== el[i] || right_din !== er[i]) begin
            n_fail++;
            $display("FAIL wrap_%0d: got wr=%b left=%h right=%h expected 1 %h %h",
                     i, left_wr_en, left_din, right_din, el[i], er[i]);
         end
         exp_count++;
         step();
      end
   endtask

   task automatic test_unbalanced();
      int n_lpr = 0;
      int n_lmr = 0;
      int n_wr  = 0;
      logic pop_l, pop_m;
      logic [31:0] got_l = '0;
      logic [31:0] got_r = '0;
      lpr_dout  = 32'h0000_1234;
      lpr_empty = 1'b0;
      lmr_empty = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         n_cmp++;
         if ({lpr_rd_en, lmr_rd_en, left_wr_en, right_wr_en} !== 4'b0000) begin
            n_fail++;
            $display("FAIL unbalanced_idle_%0d: got %b expected 0000",
                     c, {lpr_rd_en, lmr_rd_en, left_wr_en, right_wr_en});
         end
         step();
      end
      lmr_dout  = 32'h0000_0034;
      lmr_empty = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (lpr_rd_en) n_lpr++;
         if (lmr_rd_en) n_lmr++;
         if (left_wr_en && right_wr_en) begin
            n_wr++;
            got_l = left_din;
            got_r = right_din;
         end
         pop_l = lpr_rd_en;
         pop_m = lmr_rd_en;
         step();
         if (pop_l) lpr_empty = 1'b1;
         if (pop_m) lmr_empty = 1'b1;
      end
      exp_count++;
      n_cmp++;
      if (n_lpr != 1 || n_lmr != 1 || n_wr != 1) begin
         n_fail++;
         $display("FAIL unbalanced_pops: got lpr=%0d lmr=%0d wr=%0d expected 1 1 1",
                  n_lpr, n_lmr, n_wr);
      end
      n_cmp++;
      if (got_l !== 32'h0000_1268 || got_r !== 32'h0000_1200) begin
         n_fail++;
         $display("FAIL unbalanced_data: got left=%h right=%h expected 00001268 00001200",
                  got_l, got_r);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] a = 32'hDEAD_0000;
      logic [31:0] b = 32'h0000_BEEF;
      lpr_dout  = a;
      lmr_dout  = b;
      lpr_empty = 1'b0;
      lmr_empty = 1'b0;
      step();
      lpr_empty  = 1'b1;
      lmr_empty  = 1'b1;
      right_full = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         n_cmp++;
         if (left_wr_en !== 1'b0 || right_wr_en !== 1'b0 ||
             left_din !== ref_left(a, b) || right_din !== ref_right(a, b)) begin
            n_fail++;
            $display("FAIL stall_%0d: got wr=%b%b left=%h right=%h expected 00 %h %h",
                     c, left_wr_en, right_wr_en, left_din, right_din,
                     ref_left(a, b), ref_right(a, b));
         end
         step();
      end
      right_full = 1'b0;
      #1;
      n_cmp++;
      if (left_wr_en !== 1'b1 || right_wr_en !== 1'b1 ||
          left_din !== ref_left(a, b) || right_din !== ref_right(a, b)) begin
         n_fail++;
         $display("FAIL stall_release: got wr=%b%b left=%h right=%h expected 11 %h %h",
                  left_wr_en, right_wr_en, left_din, right_din,
                  ref_left(a, b), ref_right(a, b));
      end
      exp_count++;
      step();
      n_cmp++;
      if (sample_count !== exp_count || left_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_count: got count=%0d wr=%b expected %0d 0",
                  sample_count, left_wr_en, exp_count);
      end
   endtask

   task automatic test_reset_midop();
      lpr_dout  = 32'h0000_0777;
      lmr_dout  = 32'h0000_0111;
      lpr_empty = 1'b0;
      lmr_empty = 1'b0;
      step();
      lpr_empty = 1'b1;
      lmr_empty = 1'b1;
      left_full = 1'b1;
      #1;
      n_cmp++;
      if (left_din !== 32'h0000_0888 || left_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL midop_pending: got left=%h wr=%b expected 00000888 0",
                  left_din, left_wr_en);
      end
      reset = 1'b0;
      #1;
      exp_count = 0;
      n_cmp++;
      if (left_din !== 32'h0 || right_din !== 32'h0 || sample_count !== 32'h0 ||
          left_wr_en !== 1'b0 || right_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL midop_async_clear: got left=%h right=%h count=%0d wr=%b%b expected 0",
                  left_din, right_din, sample_count, left_wr_en, right_wr_en);
      end
      left_full = 1'b0;
      lpr_dout  = 32'h0000_0050;
      lmr_dout  = 32'h0000_0020;
      lpr_empty = 1'b0;
      lmr_empty = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         n_cmp++;
         if ({lpr_rd_en, lmr_rd_en, left_wr_en, right_wr_en} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midop_held_%0d: got %b expected 0000",
                     c, {lpr_rd_en, lmr_rd_en, left_wr_en, right_wr_en});
         end
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({lpr_rd_en, lmr_rd_en, left_wr_en, right_wr_en} !== 4'b1100) begin
         n_fail++;
         $display("FAIL midop_fresh_pop: got %b expected 1100",
                  {lpr_rd_en, lmr_rd_en, left_wr_en, right_wr_en});
      end
      step();
      lpr_empty = 1'b1;
      lmr_empty = 1'b1;
      #1;
      n_cmp++;
      if (left_wr_en !== 1'b1 || left_din !== 32'h0000_0070 || right_din !== 32'h0000_0030) begin
         n_fail++;
         $display("FAIL midop_fresh_data: got wr=%b left=%h right=%h expected 1 00000070 00000030",
                  left_wr_en, left_din, right_din);
      end
      exp_count++;
      step();
      n_cmp++;
      if (sample_count !== 32'd1) begin
         n_fail++;
         $display("FAIL midop_count: got %0d expected 1", sample_count);
      end
   endtask

   // Randomized stream; with stalls=0 it must sustain one pair every two cycles.
   task automatic run_stream(input int n_pairs, input bit stalls, input int budget);
      int cycles = 0;
      int writes = 0;
      logic pop;
      logic [31:0] a, b;
      src_lpr.delete();
      src_lmr.delete();
      exp_l.delete();
      exp_r.delete();
      for (int i = 0; i < n_pairs; i++) begin
         a = $urandom();
         b = $urandom();
         src_lpr.push_back(a);
         src_lmr.push_back(b);
         exp_l.push_back(ref_left(a, b));
         exp_r.push_back(ref_right(a, b));
      end
      while (writes < n_pairs && cycles < budget) begin
         lpr_empty  = (src_lpr.size() == 0) || (stalls && $urandom_range(0, 3) == 0);
         lmr_empty  = (src_lmr.size() == 0) || (stalls && $urandom_range(0, 3) == 0);
         lpr_dout   = (src_lpr.size() != 0) ? src_lpr[0] : 32'h0;
         lmr_dout   = (src_lmr.size() != 0) ? src_lmr[0] : 32'h0;
         left_full  = stalls && ($urandom_range(0, 2) == 0);
         right_full = stalls && ($urandom_range(0, 2) == 0);
         #1;
         cycles++;
         n_cmp++;
         if (lpr_rd_en !== lmr_rd_en || (lpr_rd_en && (lpr_empty || lmr_empty)) ||
             (lpr_rd_en && left_wr_en) || left_wr_en !== right_wr_en ||
             (left_wr_en && (left_full || right_full))) begin
            n_fail++;
            $display("FAIL stream_handshake_c%0d: got rd=%b%b wr=%b%b empty=%b%b full=%b%b",
                     cycles, lpr_rd_en, lmr_rd_en, left_wr_en, right_wr_en,
                     lpr_empty, lmr_empty, left_full, right_full);
         end
         if (left_wr_en && right_wr_en) begin
            n_cmp++;
            if (exp_l.size() == 0) begin
               n_fail++;
               $display("FAIL stream_extra_write: got left=%h right=%h expected none",
                        left_din, right_din);
            end else begin
               if (left_din !== exp_l[0] || right_din !== exp_r[0]) begin
                  n_fail++;
                  $display("FAIL stream_data_%0d: got left=%h right=%h expected %h %h",
                           writes, left_din, right_din, exp_l[0], exp_r[0]);
               end
               void'(exp_l.pop_front());
               void'(exp_r.pop_front());
            end
            writes++;
            exp_count++;
         end
         pop = lpr_rd_en && lmr_rd_en;
         step();
         if (pop && src_lpr.size() != 0 && src_lmr.size() != 0) begin
            void'(src_lpr.pop_front());
            void'(src_lmr.pop_front());
         end
      end
      idle_inputs();
      n_cmp++;
      if (writes != n_pairs) begin
         n_fail++;
         $display("FAIL stream_writes: got %0d expected %0d within %0d cycles",
                  writes, n_pairs, budget);
      end
      if (!stalls) begin
         n_cmp++;
         if (cycles != 2 * n_pairs) begin
            n_fail++;
            $display("FAIL stream_throughput: got %0d cycles expected %0d", cycles, 2 * n_pairs);
         end
      end
      n_cmp++;
      if (sample_count !== exp_count) begin
         n_fail++;
         $display("FAIL stream_count: got %0d expected %0d", sample_count, exp_count);
      end
   endtask

   task automatic test_stream();
      fresh_reset();
      run_stream(100, 1'b0, 400);
   endtask

   task automatic test_random_stall();
      run_stream(60, 1'b1, 3000);
   endtask

   initial begin
      idle_inputs();
      reset = 1'b0;
      test_reset();
      test_basic();
      test_wrap();
      test_unbalanced();
      test_backpressure();
      test_reset_midop();
      test_stream();
      test_random_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
